// File: rtl/rs_issue_scheduler_pkg.sv
// Types and constants shared by the issue scheduler and the reservation station.
// Build option: RS_AGE_PRIO_EN selects age priority instead of round-robin.
package rv32i_types;

  localparam int unsigned RS_SIZE  = 15;
  localparam int unsigned ROB_SIZE = 15;
  localparam int unsigned RS_IDXW  = $clog2(RS_SIZE);

  typedef logic [RS_IDXW-1:0] rs_idx_t;
  typedef logic [3:0]         rob_tag_t;

  typedef struct packed {
    logic    valid;
    rs_idx_t idx;
  } issue_req_t;

  // Distance from the ROB head; 5 bits because tag + ROB_SIZE can reach 29.
  function automatic logic [4:0] rob_age(input rob_tag_t tag, input rob_tag_t front);
    logic [4:0] s;
    s = {1'b0, tag} + 5'(ROB_SIZE) - {1'b0, front};
    if (s >= 5'(ROB_SIZE)) s = s - 5'(ROB_SIZE);
    return s;
  endfunction

endpackage

// File: rtl/rs_issue_scheduler_issue_select.sv
// Combinational single-winner pick from an eligible mask.
// Build option: RS_AGE_PRIO_EN picks the smallest age instead of round-robin from a pointer.
module issue_select #(
  parameter int unsigned SIZE = 15,
  parameter int unsigned IDXW = 4
) (
  input  logic [SIZE-1:0]      i_mask,
`ifdef RS_AGE_PRIO_EN
  input  logic [SIZE-1:0][4:0] i_age,
`else
  input  logic [IDXW-1:0]      i_ptr,
`endif
  output logic [SIZE-1:0]      o_onehot,
  output logic [IDXW-1:0]      o_idx,
  output logic                 o_found
);

`ifdef RS_AGE_PRIO_EN
  // Strict less-than keeps the lowest index on equal ages.
  always_comb begin
    logic [4:0] best;
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    best     = '1;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (i_mask[i] && (!o_found || i_age[i] < best)) begin
        o_found     = 1'b1;
        best        = i_age[i];
        o_idx       = IDXW'(i);
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
      end
    end
  end
`else
  always_comb begin
    int unsigned j;
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    j        = 0;
    for (int unsigned k = 0; k < SIZE; k++) begin
      j = (32'(i_ptr) + k) % SIZE;
      if (!o_found && i_mask[j]) begin
        o_found     = 1'b1;
        o_idx       = IDXW'(j);
        o_onehot[j] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rs_issue_scheduler.sv
// Issue scheduler: one ALU and one CMP pick per cycle into valid/ready output registers.
// Build option: RS_AGE_PRIO_EN replaces round-robin with oldest-first (ROB age) priority.
module rs_issue_scheduler #(
  parameter int unsigned SIZE     = rv32i_types::RS_SIZE,
  parameter int unsigned ROB_SIZE = rv32i_types::ROB_SIZE,
  parameter int unsigned IDXW     = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_valid,
  input  logic [SIZE-1:0]       rs_ready,
  input  logic [SIZE-1:0]       rs_acu,
  input  logic [SIZE-1:0][3:0]  rs_tag,
  input  logic [3:0]            rob_front_tag,
  input  logic [SIZE-1:0]       rs_done,
  output logic                  alu_valid,
  output logic [IDXW-1:0]       alu_idx,
  input  logic                  alu_ready,
  output logic                  cmp_valid,
  output logic [IDXW-1:0]       cmp_idx,
  input  logic                  cmp_ready,
  output logic [SIZE-1:0]       issued,
  output logic [15:0]           stall_cycles
);
  import rv32i_types::*;

  issue_req_t       r_alu, r_cmp;
  logic [SIZE-1:0]  r_issued;
  logic [15:0]      r_stall;

  logic [SIZE-1:0]  w_elig_alu, w_elig_cmp;
  logic [SIZE-1:0]  w_oh_alu, w_oh_cmp, w_set;
  logic [IDXW-1:0]  w_idx_alu, w_idx_cmp;
  logic             w_found_alu, w_found_cmp;
  logic             w_ld_alu, w_ld_cmp, w_stall;

  assign w_elig_alu = rs_ready & ~r_issued & ~rs_done & ~rs_acu;
  assign w_elig_cmp = rs_ready & ~r_issued & ~rs_done &  rs_acu;
  assign w_ld_alu   = ~r_alu.valid | alu_ready;
  assign w_ld_cmp   = ~r_cmp.valid | cmp_ready;
  assign w_stall    = (r_alu.valid & ~alu_ready) | (r_cmp.valid & ~cmp_ready);
  assign w_set      = ((w_ld_alu & w_found_alu) ? w_oh_alu : '0)
                    | ((w_ld_cmp & w_found_cmp) ? w_oh_cmp : '0);

`ifdef RS_AGE_PRIO_EN
  logic [SIZE-1:0][4:0] w_age;

  always_comb begin
    w_age = '0;
    for (int unsigned i = 0; i < SIZE; i++) w_age[i] = rob_age(rs_tag[i], rob_front_tag);
  end

  issue_select #(.SIZE(SIZE), .IDXW(IDXW)) u_sel_alu (
    .i_mask(w_elig_alu), .i_age(w_age),
    .o_onehot(w_oh_alu), .o_idx(w_idx_alu), .o_found(w_found_alu));
  issue_select #(.SIZE(SIZE), .IDXW(IDXW)) u_sel_cmp (
    .i_mask(w_elig_cmp), .i_age(w_age),
    .o_onehot(w_oh_cmp), .o_idx(w_idx_cmp), .o_found(w_found_cmp));
`else
  logic [IDXW-1:0] r_alu_ptr, r_cmp_ptr;
  logic            w_unused;

  assign w_unused = ^{rs_tag, rob_front_tag};

  issue_select #(.SIZE(SIZE), .IDXW(IDXW)) u_sel_alu (
    .i_mask(w_elig_alu), .i_ptr(r_alu_ptr),
    .o_onehot(w_oh_alu), .o_idx(w_idx_alu), .o_found(w_found_alu));
  issue_select #(.SIZE(SIZE), .IDXW(IDXW)) u_sel_cmp (
    .i_mask(w_elig_cmp), .i_ptr(r_cmp_ptr),
    .o_onehot(w_oh_cmp), .o_idx(w_idx_cmp), .o_found(w_found_cmp));

  // Pointers survive flush; they only move on an actual grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_ptr <= '0;
      r_cmp_ptr <= '0;
    end else if (!flush_valid) begin
      if (w_ld_alu && w_found_alu)
        r_alu_ptr <= (w_idx_alu == IDXW'(SIZE-1)) ? '0 : w_idx_alu + 1'b1;
      if (w_ld_cmp && w_found_cmp)
        r_cmp_ptr <= (w_idx_cmp == IDXW'(SIZE-1)) ? '0 : w_idx_cmp + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu    <= '0;
      r_cmp    <= '0;
      r_issued <= '0;
      r_stall  <= '0;
    end else begin
      if (w_stall && r_stall != '1) r_stall <= r_stall + 1'b1;
      if (flush_valid) begin
        r_alu.valid <= 1'b0;
        r_cmp.valid <= 1'b0;
        r_issued    <= '0;
      end else begin
        r_issued <= (r_issued | w_set) & ~rs_done;
        // A held request whose entry completes is dropped rather than issued stale.
        if (w_ld_alu) begin
          r_alu.valid <= w_found_alu;
          if (w_found_alu) r_alu.idx <= w_idx_alu;
        end else if (rs_done[r_alu.idx]) begin
          r_alu.valid <= 1'b0;
        end
        if (w_ld_cmp) begin
          r_cmp.valid <= w_found_cmp;
          if (w_found_cmp) r_cmp.idx <= w_idx_cmp;
        end else if (rs_done[r_cmp.idx]) begin
          r_cmp.valid <= 1'b0;
        end
      end
    end
  end

  assign alu_valid    = r_alu.valid;
  assign alu_idx      = r_alu.idx;
  assign cmp_valid    = r_cmp.valid;
  assign cmp_idx      = r_cmp.idx;
  assign issued       = r_issued;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed vector bench for rs_issue_scheduler (round-robin table; age sequence under RS_AGE_PRIO_EN).
module tb_rs_issue_scheduler;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_valid;
  logic [14:0]      rs_ready, rs_acu, rs_done;
  logic [14:0][3:0] rs_tag;
  logic [3:0]       rob_front_tag;
  logic             alu_valid, alu_ready, cmp_valid, cmp_ready;
  logic [3:0]       alu_idx, cmp_idx;
  logic [14:0]      issued;
  logic [15:0]      stall_cycles;

  int n_cmp  = 0;
  int n_miss = 0;

  rs_issue_scheduler dut (
    .clk(clk), .rst(rst), .flush_valid(flush_valid),
    .rs_ready(rs_ready), .rs_acu(rs_acu), .rs_tag(rs_tag),
    .rob_front_tag(rob_front_tag), .rs_done(rs_done),
    .alu_valid(alu_valid), .alu_idx(alu_idx), .alu_ready(alu_ready),
    .cmp_valid(cmp_valid), .cmp_idx(cmp_idx), .cmp_ready(cmp_ready),
    .issued(issued), .stall_cycles(stall_cycles));

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] ready, acu, done;
    logic        ar, cr, fl;
    logic        av;
    logic [3:0]  ai;
    logic        cv;
    logic [3:0]  ci;
    logic [14:0] iss;
    logic [15:0] st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [14:0] ready, acu, done, input logic ar, cr, fl,
                     input logic av, input logic [3:0] ai, input logic cv,
                     input logic [3:0] ci, input logic [14:0] iss, input logic [15:0] st);
    vec_t v;
    v.ready = ready; v.acu = acu; v.done = done; v.ar = ar; v.cr = cr; v.fl = fl;
    v.av = av; v.ai = ai; v.cv = cv; v.ci = ci; v.iss = iss; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush_valid = 1'b0; rs_ready = '0; rs_acu = '0; rs_done = '0;
    rs_tag = '0; rob_front_tag = '0; alu_ready = 1'b1; cmp_ready = 1'b1;
    step(); step();
    chk("reset alu_valid", 32'(alu_valid), 0);
    chk("reset cmp_valid", 32'(cmp_valid), 0);
    chk("reset alu_idx",   32'(alu_idx), 0);
    chk("reset cmp_idx",   32'(cmp_idx), 0);
    chk("reset issued",    32'(issued), 0);
    chk("reset stall",     32'(stall_cycles), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;

`ifdef RS_AGE_PRIO_EN
    rob_front_tag = 4'd13;
    rs_tag[2] = 4'd1;
    rs_tag[7] = 4'd14;
    rs_ready = 15'h0084;
    step();
    chk("age first valid", 32'(alu_valid), 1);
    chk("age first idx",   32'(alu_idx), 7);
    step();
    chk("age second idx",  32'(alu_idx), 2);
    chk("age issued",      32'(issued), 32'h0084);
`else
    //    ready     acu       done      ar cr fl  av ai  cv ci  issued    stall
    add(15'h0007, 15'h0000, 15'h0000, 1, 1, 0, 1, 0,  0, 0, 15'h0001, 0); // rr fairness
    add(15'h0007, 15'h0000, 15'h0000, 1, 1, 0, 1, 1,  0, 0, 15'h0003, 0);
    add(15'h0007, 15'h0000, 15'h0000, 1, 1, 0, 1, 2,  0, 0, 15'h0007, 0);
    add(15'h0007, 15'h0000, 15'h0000, 1, 1, 0, 0, 2,  0, 0, 15'h0007, 0);
    add(15'h0000, 15'h0000, 15'h0007, 1, 1, 0, 0, 2,  0, 0, 15'h0000, 0);
    add(15'h0018, 15'h0000, 15'h0000, 0, 1, 0, 1, 3,  0, 0, 15'h0008, 0); // back-pressure
    add(15'h0018, 15'h0000, 15'h0000, 0, 1, 0, 1, 3,  0, 0, 15'h0008, 1);
    add(15'h0018, 15'h0000, 15'h0000, 0, 1, 0, 1, 3,  0, 0, 15'h0008, 2);
    add(15'h0018, 15'h0000, 15'h0000, 0, 1, 0, 1, 3,  0, 0, 15'h0008, 3);
    add(15'h0018, 15'h0000, 15'h0000, 1, 1, 0, 1, 4,  0, 0, 15'h0018, 3);
    add(15'h0018, 15'h0000, 15'h0008, 1, 1, 0, 0, 4,  0, 0, 15'h0010, 3);
    add(15'h0020, 15'h0020, 15'h0000, 1, 0, 0, 0, 4,  1, 5, 15'h0030, 3); // cmp + done drop
    add(15'h0020, 15'h0020, 15'h0000, 1, 0, 0, 0, 4,  1, 5, 15'h0030, 4);
    add(15'h0020, 15'h0020, 15'h0020, 1, 0, 0, 0, 4,  0, 5, 15'h0010, 5);
    add(15'h00C0, 15'h0080, 15'h0000, 1, 1, 0, 1, 6,  1, 7, 15'h00D0, 5); // flush
    add(15'h00C0, 15'h0080, 15'h0000, 0, 0, 1, 0, 6,  0, 7, 15'h0000, 6);
    add(15'h00C0, 15'h0080, 15'h0000, 1, 1, 0, 1, 6,  1, 7, 15'h00C0, 6);
    add(15'h0000, 15'h0000, 15'h00C0, 1, 1, 0, 0, 6,  0, 7, 15'h0000, 6);
    add(15'h2000, 15'h0000, 15'h0000, 1, 1, 0, 1, 13, 0, 7, 15'h2000, 6); // wrap
    add(15'h4001, 15'h0000, 15'h2000, 1, 1, 0, 1, 14, 0, 7, 15'h4000, 6);
    add(15'h4001, 15'h0000, 15'h0000, 1, 1, 0, 1, 0,  0, 7, 15'h4001, 6);
    add(15'h0006, 15'h0000, 15'h4001, 1, 1, 0, 1, 1,  0, 7, 15'h0002, 6);
    add(15'h0004, 15'h0000, 15'h0000, 1, 1, 0, 1, 2,  0, 7, 15'h0006, 6);

    foreach (tbl[i]) begin
      rs_ready = tbl[i].ready; rs_acu = tbl[i].acu; rs_done = tbl[i].done;
      alu_ready = tbl[i].ar; cmp_ready = tbl[i].cr; flush_valid = tbl[i].fl;
      step();
      chk($sformatf("v%0d alu_valid", i), 32'(alu_valid), 32'(tbl[i].av));
      chk($sformatf("v%0d alu_idx", i),   32'(alu_idx),   32'(tbl[i].ai));
      chk($sformatf("v%0d cmp_valid", i), 32'(cmp_valid), 32'(tbl[i].cv));
      chk($sformatf("v%0d cmp_idx", i),   32'(cmp_idx),   32'(tbl[i].ci));
      chk($sformatf("v%0d issued", i),    32'(issued),    32'(tbl[i].iss));
      chk($sformatf("v%0d stall", i),     32'(stall_cycles), 32'(tbl[i].st));
    end
`endif

    // Asynchronous reset mid-issue: outputs clear without waiting for a clock edge.
    #3;
    chk("pre-reset alu_valid", 32'(alu_valid), 1);
    rst = 1'b0;
    #1;
    chk("async alu_valid", 32'(alu_valid), 0);
    chk("async cmp_valid", 32'(cmp_valid), 0);
    chk("async alu_idx",   32'(alu_idx), 0);
    chk("async issued",    32'(issued), 0);
    chk("async stall",     32'(stall_cycles), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
